// File: rtl/onehot_rr_arbiter_if.sv
// rtl/onehot_rr_arbiter_if.sv - request/grant bundle between requesters, arbiter and 8-to-3 encoder
//
// Signals:
//   req          requester -> arbiter  N  level requests, bit i = requester i
//   grant        arbiter -> encoder    N  registered one-hot grant, zero when not valid
//   grant_valid  arbiter -> encoder    1  grant holds a valid one-hot code
//   grant_ready  encoder -> arbiter    1  grant accepted this cycle
//   pending      arbiter -> status     N  captured, not-yet-granted requests
//   idle         arbiter -> status     1  no grant outstanding and nothing pending
//
// Modports:
//   master  the arbiter (drives grant side, receives req/grant_ready)
//   slave   the requesters/encoder side
interface onehot_rr_arbiter_if #(
  parameter int N = 8
);
  logic [N-1:0] req;
  logic [N-1:0] grant;
  logic         grant_valid;
  logic         grant_ready;
  logic [N-1:0] pending;
  logic         idle;

  modport master (
    input  req,
    input  grant_ready,
    output grant,
    output grant_valid,
    output pending,
    output idle
  );

  modport slave (
    output req,
    output grant_ready,
    input  grant,
    input  grant_valid,
    input  pending,
    input  idle
  );
endinterface

// File: rtl/onehot_rr_arbiter.sv
// rtl/onehot_rr_arbiter.sv - edge-capturing round-robin arbiter with one-hot valid/ready grant
//
// Captures rising edges on 8 request lines into a pending set and hands out
// one registered, strictly one-hot grant at a time to the downstream encoder.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   onehot_rr_arbiter_if.master (req, grant, grant_valid, grant_ready,
//         pending, idle)
//
// Build option:
//   ARB_FIXED_PRI_EN  highest-index pending requester wins; no round-robin pointer
module onehot_rr_arbiter #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  onehot_rr_arbiter_if.master   bus
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  state_t           state;
  state_t           state_next;

  logic [N-1:0]     req_d;
  logic [N-1:0]     pending;
  logic [N-1:0]     pending_next;
  logic [N-1:0]     rise;
  logic [N-1:0]     clr;
  logic             accept;

  logic [N-1:0]     grant_q;
  logic [N-1:0]     grant_next;
  logic             grant_valid_q;
  logic             grant_valid_next;

  logic [IDX_W-1:0] sel_idx;

  // ---------------------------------------------------------------------------
  // Request edge capture
  // ---------------------------------------------------------------------------
  assign accept = grant_valid_q & bus.grant_ready;
  assign rise   = bus.req & ~req_d;
  assign clr    = accept ? grant_q : '0;

  // A new rise on the bit being accepted must survive the clear, so the set
  // term is applied after the clear.
  assign pending_next = (pending & ~clr) | rise;

  // ---------------------------------------------------------------------------
  // Winner selection
  // ---------------------------------------------------------------------------
`ifdef ARB_FIXED_PRI_EN
  // Highest index wins: ascending scan, last hit overwrites.
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (pending[i]) begin
        sel_idx = IDX_W'(i);
      end
    end
  end
`else
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] cand;

  // Scan offsets N..1 from ptr; the smallest offset is visited last and so
  // overrides, giving priority ptr+1, ptr+2, ... with natural mod-N wrap.
  always_comb begin
    sel_idx = '0;
    cand    = '0;
    for (int k = N; k >= 1; k--) begin
      cand = ptr + IDX_W'(k);
      if (pending[cand]) begin
        sel_idx = cand;
      end
    end
  end

  // win_idx remembers who holds the grant so the pointer can move to it on
  // accept without re-encoding the grant vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= IDX_W'(N - 1);
      win_idx <= '0;
    end else begin
      if ((state == S_IDLE) && (|pending)) begin
        win_idx <= sel_idx;
      end
      if (accept) begin
        ptr <= win_idx;
      end
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (|pending) begin
          state_next = S_GRANT;
        end
      end
      S_GRANT: begin
        // grant_valid is always high in GRANT, so ready alone means accept.
        if (bus.grant_ready) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output decode (next values of the registered grant)
  // ---------------------------------------------------------------------------
  always_comb begin
    grant_next       = grant_q;
    grant_valid_next = grant_valid_q;
    case (state)
      S_IDLE: begin
        grant_next       = '0;
        grant_valid_next = 1'b0;
        if (|pending) begin
          grant_next       = ONE << sel_idx;
          grant_valid_next = 1'b1;
        end
      end
      S_GRANT: begin
        // Hold stable under backpressure; drop for one IDLE cycle on accept.
        if (bus.grant_ready) begin
          grant_next       = '0;
          grant_valid_next = 1'b0;
        end
      end
      default: begin
        grant_next       = '0;
        grant_valid_next = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      req_d         <= '0;
      pending       <= '0;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
    end else begin
      req_d         <= bus.req;
      pending       <= pending_next;
      grant_q       <= grant_next;
      grant_valid_q <= grant_valid_next;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.pending     = pending;
  assign bus.idle        = (state == S_IDLE) && (pending == '0);

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// tb/tb_onehot_rr_arbiter.sv - directed self-checking bench for onehot_rr_arbiter
module tb_onehot_rr_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;

  onehot_rr_arbiter_if #(.N(8)) bus ();

  onehot_rr_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

`ifdef ARB_FIXED_PRI_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  logic [7:0] exp_g;

  initial begin
    // Reset with all requests held high
    rst             = 1'b1;
    bus.req         = 8'hFF;
    bus.grant_ready = 1'b0;
    tick();
    tick();
    chk ("rst_grant",   bus.grant,       8'h00);
    chk1("rst_valid",   bus.grant_valid, 1'b0);
    chk ("rst_pending", bus.pending,     8'h00);
    chk1("rst_idle",    bus.idle,        1'b1);

    rst = 1'b0;
    tick();
    chk ("post_rst_pending", bus.pending,     8'hFF);
    chk1("post_rst_valid0",  bus.grant_valid, 1'b0);
    tick();
    chk1("post_rst_valid1",  bus.grant_valid, 1'b1);

    // Fairness: 8 accepts with everything pending
    bus.grant_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_g = FIXED ? (8'h80 >> i) : (8'h01 << i);
      chk("fair_grant", bus.grant, exp_g);
      tick();
      chk1("fair_gap_valid", bus.grant_valid, 1'b0);
      tick();
    end
    chk1("fair_end_valid",   bus.grant_valid, 1'b0);
    chk ("fair_end_pending", bus.pending,     8'h00);
    chk1("fair_end_idle",    bus.idle,        1'b1);

    // Single request
    bus.req = 8'h00;
    tick();
    bus.req = 8'h04;
    tick();
    chk ("single_pending", bus.pending,     8'h04);
    chk1("single_valid0",  bus.grant_valid, 1'b0);
    tick();
    chk ("single_grant",   bus.grant,       8'h04);
    chk1("single_valid1",  bus.grant_valid, 1'b1);
    tick();
    chk1("single_acc_valid",   bus.grant_valid, 1'b0);
    chk ("single_acc_pending", bus.pending,     8'h00);
    chk1("single_acc_idle",    bus.idle,        1'b1);
    tick();
    tick();
    tick();
    chk1("single_held_nogrant", bus.grant_valid, 1'b0);

    // Round-robin wrap from the reset pointer
    bus.req = 8'h00;
    rst     = 1'b1;
    tick();
    rst     = 1'b0;
    bus.req = 8'h81;
    tick();
    bus.req = 8'h00;
    tick();
    chk("wrap_grant1", bus.grant, FIXED ? 8'h80 : 8'h01);
    tick();
    tick();
    chk("wrap_grant2", bus.grant, FIXED ? 8'h01 : 8'h80);
    tick();
    bus.req = 8'h81;
    tick();
    bus.req = 8'h00;
    tick();
    chk("wrap_grant3", bus.grant, FIXED ? 8'h80 : 8'h01);
    tick();
    tick();
    tick();
    chk ("wrap_end_pending", bus.pending, 8'h00);
    chk1("wrap_end_idle",    bus.idle,    1'b1);

    // Backpressure with a new request arriving during GRANT
    bus.grant_ready = 1'b0;
    bus.req         = 8'h10;
    tick();
    tick();
    chk ("bp_grant",  bus.grant,       8'h10);
    chk1("bp_valid",  bus.grant_valid, 1'b1);
    bus.req = 8'h14;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk ("bp_hold_grant", bus.grant,       8'h10);
      chk1("bp_hold_valid", bus.grant_valid, 1'b1);
    end
    chk("bp_pending", bus.pending, 8'h14);
    bus.grant_ready = 1'b1;
    tick();
    chk1("bp_acc_valid",   bus.grant_valid, 1'b0);
    chk ("bp_acc_grant",   bus.grant,       8'h00);
    chk ("bp_acc_pending", bus.pending,     8'h04);
    tick();
    chk ("bp_next_grant",  bus.grant,       8'h04);
    tick();
    chk ("bp_end_pending", bus.pending,     8'h00);

    // Set/clear collision on bit 1
    bus.grant_ready = 1'b0;
    bus.req         = 8'h02;
    tick();
    bus.req = 8'h00;
    tick();
    chk("coll_grant", bus.grant, 8'h02);
    bus.grant_ready = 1'b1;
    bus.req         = 8'h02;
    tick();
    chk ("coll_pending", bus.pending,     8'h02);
    chk1("coll_valid0",  bus.grant_valid, 1'b0);
    tick();
    chk ("coll_regrant", bus.grant,       8'h02);
    chk1("coll_valid1",  bus.grant_valid, 1'b1);
    tick();
    chk ("coll_end_pending", bus.pending, 8'h00);
    chk1("coll_end_idle",    bus.idle,    1'b1);

    // Reset while a grant is outstanding
    bus.grant_ready = 1'b0;
    bus.req         = 8'h08;
    tick();
    tick();
    chk("mid_grant", bus.grant, 8'h08);
    rst     = 1'b1;
    bus.req = 8'h00;
    tick();
    chk ("mid_rst_grant",   bus.grant,       8'h00);
    chk1("mid_rst_valid",   bus.grant_valid, 1'b0);
    chk ("mid_rst_pending", bus.pending,     8'h00);
    chk1("mid_rst_idle",    bus.idle,        1'b1);
    rst     = 1'b0;
    bus.req = 8'h81;
    tick();
    bus.req = 8'h00;
    tick();
    chk("mid_rst_ptr_grant", bus.grant, FIXED ? 8'h80 : 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
